// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: shared types and constants for the peak-current-mode PWM
// controller and its period timer.
//   pwm_state_e      : controller states IDLE / ON / OFF / FAULT
//   IEST_ZERO_CODE   : estimator code at zero coil current
//   IEST_DN_PER_A    : estimator codes per ampere (code falls as current rises)
//   PERIOD_W / ON_W  : counter widths, sized for PERIOD_CYCLES up to 4095
package pwm_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ON    = 2'd1,
        OFF   = 2'd2,
        FAULT = 2'd3
    } pwm_state_e;

    localparam logic [11:0] IEST_ZERO_CODE = 12'd2047;
    localparam int          IEST_DN_PER_A  = 205;

    localparam int CODE_W   = 12;
    localparam int PERIOD_W = 12;
    localparam int ON_W     = 12;

endpackage

// File: rtl/pwm_peak_ctrl_if.sv
// pwm_peak_ctrl_if: control/status bundle between the sequencer and the
// peak-current PWM controller.
//   master : sequencer side, drives enable, fault, ipk_code, iest_coil
//            (and slope when PWM_SLOPE_COMP_EN is defined)
//   slave  : controller side, drives pwm, period_start, trip_pk, trip_max,
//            fault_lat
// Optional macro: PWM_SLOPE_COMP_EN adds the 8-bit slope input.
interface pwm_peak_ctrl_if;

    logic        enable;
    logic        fault;
    logic [11:0] ipk_code;
    logic [11:0] iest_coil;
`ifdef PWM_SLOPE_COMP_EN
    logic [7:0]  slope;
`endif
    logic        pwm;
    logic        period_start;
    logic        trip_pk;
    logic        trip_max;
    logic        fault_lat;

`ifdef PWM_SLOPE_COMP_EN
    modport master (output enable, fault, ipk_code, iest_coil, slope,
                    input  pwm, period_start, trip_pk, trip_max, fault_lat);
    modport slave  (input  enable, fault, ipk_code, iest_coil, slope,
                    output pwm, period_start, trip_pk, trip_max, fault_lat);
`else
    modport master (output enable, fault, ipk_code, iest_coil,
                    input  pwm, period_start, trip_pk, trip_max, fault_lat);
    modport slave  (input  enable, fault, ipk_code, iest_coil,
                    output pwm, period_start, trip_pk, trip_max, fault_lat);
`endif

endinterface

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running switching-period counter.
//   clk, reset : clock and synchronous active-high reset
//   wrap_o     : high during the last cycle of each period, i.e. the edge
//                that follows is the period boundary
module pwm_period_timer
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD_CYCLES = 48
) (
    input  logic clk,
    input  logic reset,
    output logic wrap_o
);

    localparam logic [PERIOD_W-1:0] LAST = PERIOD_W'(PERIOD_CYCLES - 1);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;

    assign wrap_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = wrap_o ? '0 : cnt_q + PERIOD_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/pwm_peak_ctrl.sv
// pwm_peak_ctrl: peak-current-mode PWM generator. A period starts on every
// timer wrap (when enabled and fault-free); the on-time ends when the coil
// current estimate reaches the latched peak threshold (after leading-edge
// blanking) or when the maximum on-time is reached.
//   clk, reset : 48 MHz clock, synchronous active-high reset
//   bus        : pwm_peak_ctrl_if.slave (enable, fault, ipk_code, iest_coil,
//                pwm, period_start, trip_pk, trip_max, fault_lat)
// Optional macro: PWM_SLOPE_COMP_EN adds a registered, saturating slope
// compensation ramp to the threshold (one extra clk on the compare path).
module pwm_peak_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD_CYCLES = 48,
    parameter int MAX_ON_CYCLES = 40,
    parameter int LEB_CYCLES    = 3
) (
    input  logic             clk,
    input  logic             reset,
    pwm_peak_ctrl_if.slave   bus
);

    localparam logic [ON_W-1:0] LEB_C    = ON_W'(LEB_CYCLES);
    localparam logic [ON_W-1:0] MAX_LAST = ON_W'(MAX_ON_CYCLES - 1);

    pwm_state_e        state_q, state_d;
    logic [ON_W-1:0]   on_cnt_q, on_cnt_d;
    logic [CODE_W-1:0] thr_base_q;
    logic [CODE_W-1:0] thr;
    logic pwm_q, pwm_d;
    logic period_start_q, period_start_d;
    logic trip_pk_q, trip_pk_d;
    logic trip_max_q, trip_max_d;
    logic fault_lat_q, fault_lat_d;
    logic wrap, start_ok, start_take, peak_hit;

    pwm_period_timer #(.PERIOD_CYCLES(PERIOD_CYCLES)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .wrap_o (wrap)
    );

`ifdef PWM_SLOPE_COMP_EN
    logic [7:0]        slope_q;
    logic [CODE_W-1:0] thr_q;

    // base + slope*n fits in 20 bits for all legal operands; clamp to full scale
    function automatic logic [CODE_W-1:0] sat_thr(input logic [CODE_W-1:0] base,
                                                   input logic [7:0]        slp,
                                                   input logic [ON_W-1:0]   n);
        logic [19:0] sum;
        sum = 20'(base) + 20'(slp) * 20'(n);
        return (sum > 20'd4095) ? 12'hFFF : sum[CODE_W-1:0];
    endfunction

    assign thr = thr_q;
`else
    assign thr = thr_base_q;
`endif

    assign start_ok = wrap & bus.enable & ~fault_lat_q & ~bus.fault;
    // Lower code means more current, so "reached the peak" is code <= thr
    assign peak_hit = (on_cnt_q >= LEB_C) && (bus.iest_coil <= thr);

    always_comb begin
        state_d        = state_q;
        on_cnt_d       = on_cnt_q;
        pwm_d          = 1'b0;
        period_start_d = 1'b0;
        trip_pk_d      = 1'b0;
        trip_max_d     = 1'b0;
        start_take     = 1'b0;
        // Sticky until an edge sees both enable and fault low
        fault_lat_d    = bus.fault | (fault_lat_q & bus.enable);

        case (state_q)
            IDLE: begin
                if (start_ok) start_take = 1'b1;
            end
            ON: begin
                pwm_d    = 1'b1;
                on_cnt_d = on_cnt_q + ON_W'(1);
                if (bus.fault || fault_lat_q) begin
                    state_d = FAULT;
                    pwm_d   = 1'b0;
                end else if (!bus.enable) begin
                    state_d = IDLE;
                    pwm_d   = 1'b0;
                end else if (peak_hit) begin
                    // Peak wins over a coincident max-duty limit
                    state_d   = OFF;
                    pwm_d     = 1'b0;
                    trip_pk_d = 1'b1;
                end else if (on_cnt_q == MAX_LAST) begin
                    state_d    = OFF;
                    pwm_d      = 1'b0;
                    trip_max_d = 1'b1;
                end
            end
            OFF: begin
                if (bus.fault) begin
                    state_d = FAULT;
                end else if (wrap) begin
                    if (start_ok) start_take = 1'b1;
                    else          state_d    = IDLE;
                end
            end
            FAULT: begin
                if (!fault_lat_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (start_take) begin
            state_d        = ON;
            pwm_d          = 1'b1;
            period_start_d = 1'b1;
            on_cnt_d       = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            on_cnt_q       <= '0;
            pwm_q          <= 1'b0;
            period_start_q <= 1'b0;
            trip_pk_q      <= 1'b0;
            trip_max_q     <= 1'b0;
            fault_lat_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            on_cnt_q       <= on_cnt_d;
            pwm_q          <= pwm_d;
            period_start_q <= period_start_d;
            trip_pk_q      <= trip_pk_d;
            trip_max_q     <= trip_max_d;
            fault_lat_q    <= fault_lat_d;
        end
    end

    // Threshold operands are captured at period start and only read in ON
    always_ff @(posedge clk) begin
        if (start_take) thr_base_q <= bus.ipk_code;
`ifdef PWM_SLOPE_COMP_EN
        if (start_take) begin
            slope_q <= bus.slope;
            thr_q   <= bus.ipk_code;
        end else if (state_q == ON) begin
            thr_q   <= sat_thr(thr_base_q, slope_q, on_cnt_q);
        end
`endif
    end

    assign bus.pwm          = pwm_q;
    assign bus.period_start = period_start_q;
    assign bus.trip_pk      = trip_pk_q;
    assign bus.trip_max     = trip_max_q;
    assign bus.fault_lat    = fault_lat_q;

endmodule

// File: tb/tb_pwm_peak_ctrl.sv
// tb_pwm_peak_ctrl: self-checking bench for pwm_peak_ctrl. Each on-time is
// predicted from a per-period coil-current profile: the pulse ends one
// cycle after the first post-blanking on-cycle whose code is at or below
// the threshold latched at period start, otherwise after MAX_ON cycles.
module tb_pwm_peak_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int PER   = 48;
    localparam int MAXON = 40;
    localparam int LEB   = 3;

    logic clk = 1'b0;
    logic reset;

    pwm_peak_ctrl_if bus ();

    pwm_peak_ctrl #(
        .PERIOD_CYCLES (PER),
        .MAX_ON_CYCLES (MAXON),
        .LEB_CYCLES    (LEB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [11:0] prof [0:63];

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic fill_const(input logic [11:0] v);
        for (int k = 0; k < 64; k++) prof[k] = v;
    endtask

    task automatic fill_ramp(input int s, input int r);
        for (int k = 0; k < 64; k++) begin
            int v;
            v = s - r * k;
            prof[k] = (v < 0) ? 12'd0 : 12'(v);
        end
    endtask

    function automatic void model_on(input logic [11:0] thr, output int len, output bit pk);
        len = MAXON;
        pk  = 1'b0;
        for (int k = 0; k < MAXON; k++) begin
            if (k >= LEB && prof[k] <= thr) begin
                len = k + 1;
                pk  = 1'b1;
                return;
            end
        end
    endfunction

    task automatic wait_start(output bit found, output int pwm_hi);
        found  = 1'b0;
        pwm_hi = 0;
        for (int i = 0; i < 2 * PER + 2; i++) begin
            tick();
            if (bus.period_start === 1'b1) begin
                found = 1'b1;
                break;
            end
            if (bus.pwm !== 1'b0) pwm_hi++;
        end
    endtask

    task automatic run_on(input bit scramble, output int len, output bit pk, output bit mx);
        len = -1;
        pk  = 1'b0;
        mx  = 1'b0;
        for (int k = 0; k < MAXON + 4; k++) begin
            bus.iest_coil = prof[k];
            if (scramble) bus.ipk_code = 12'($urandom);
            tick();
            if (bus.pwm !== 1'b1) begin
                len = k + 1;
                pk  = bus.trip_pk;
                mx  = bus.trip_max;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.enable = 1'b0;
        bus.fault = 1'b0;
        bus.ipk_code = 12'd0;
        bus.iest_coil = IEST_ZERO_CODE;
        repeat (3) tick();
        n_checks++; if (bus.pwm !== 1'b0) $display("FAIL reset_pwm got %b want 0", bus.pwm); else n_pass++;
        n_checks++; if (bus.period_start !== 1'b0) $display("FAIL reset_period_start got %b want 0", bus.period_start); else n_pass++;
        n_checks++; if (bus.trip_pk !== 1'b0) $display("FAIL reset_trip_pk got %b want 0", bus.trip_pk); else n_pass++;
        n_checks++; if (bus.trip_max !== 1'b0) $display("FAIL reset_trip_max got %b want 0", bus.trip_max); else n_pass++;
        n_checks++; if (bus.fault_lat !== 1'b0) $display("FAIL reset_fault_lat got %b want 0", bus.fault_lat); else n_pass++;
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic test_startup();
        bit found, pk, mx, epk;
        int hi, len, elen;
        bus.ipk_code = 12'd1637;
        fill_const(IEST_ZERO_CODE);
        bus.enable = 1'b1;
        wait_start(found, hi);
        n_checks++; if (!found || cyc != PER) $display("FAIL startup_first_wrap got found=%0d cyc=%0d want cyc=%0d", found, cyc, PER); else n_pass++;
        n_checks++; if (hi != 0) $display("FAIL startup_no_early_pwm got %0d high cycles want 0", hi); else n_pass++;
        run_on(1'b0, len, pk, mx);
        model_on(12'd1637, elen, epk);
        n_checks++; if (len != elen) $display("FAIL startup_on_len got %0d want %0d", len, elen); else n_pass++;
        n_checks++; if (pk !== epk || mx !== !epk) $display("FAIL startup_trip got pk=%b mx=%b want pk=%b mx=%b", pk, mx, epk, !epk); else n_pass++;
        tick();
        n_checks++; if (bus.trip_pk !== 1'b0 || bus.trip_max !== 1'b0) $display("FAIL startup_trip_width got pk=%b mx=%b want 0 0", bus.trip_pk, bus.trip_max); else n_pass++;
    endtask

    // Directed single-period scenario: fixed threshold, prepared profile
    task automatic test_profile(input string name, input logic [11:0] ipk, input bit scramble);
        bit found, pk, mx, epk;
        int hi, len, elen;
        bus.ipk_code = ipk;
        wait_start(found, hi);
        n_checks++; if (!found || (cyc % PER) != 0) $display("FAIL %s_start got found=%0d phase=%0d want 1 0", name, found, cyc % PER); else n_pass++;
        run_on(scramble, len, pk, mx);
        model_on(ipk, elen, epk);
        n_checks++; if (len != elen) $display("FAIL %s_on_len got %0d want %0d", name, len, elen); else n_pass++;
        n_checks++; if (pk !== epk || mx !== !epk) $display("FAIL %s_trip got pk=%b mx=%b want pk=%b mx=%b", name, pk, mx, epk, !epk); else n_pass++;
        tick();
        n_checks++; if (bus.trip_pk !== 1'b0 || bus.trip_max !== 1'b0) $display("FAIL %s_trip_width got pk=%b mx=%b want 0 0", name, bus.trip_pk, bus.trip_max); else n_pass++;
    endtask

    task automatic test_peak();
        fill_ramp(2047, 41);
        test_profile("peak", 12'd1637, 1'b1);
    endtask

    task automatic test_blanking();
        fill_const(IEST_ZERO_CODE);
        for (int k = 0; k < LEB; k++) prof[k] = 12'd0;
        test_profile("blanking", 12'd1637, 1'b0);
    endtask

    task automatic test_coincide();
        fill_const(IEST_ZERO_CODE);
        prof[MAXON-1] = 12'd0;
        test_profile("coincide", 12'd1637, 1'b0);
    endtask

    task automatic test_ipk_fff();
        fill_const(IEST_ZERO_CODE);
        test_profile("ipk_fff", 12'hFFF, 1'b0);
    endtask

    task automatic test_random(input int n);
        bit found, pk, mx, epk;
        int hi, len, elen, prev;
        logic [11:0] ipk;
        prev = -1;
        for (int i = 0; i < n; i++) begin
            ipk = 12'($urandom_range(0, 4095));
            fill_ramp($urandom_range(1200, 4095), $urandom_range(0, 150));
            bus.ipk_code = ipk;
            wait_start(found, hi);
            n_checks++; if (!found || hi != 0) $display("FAIL rand%0d_start got found=%0d off_high=%0d want 1 0", i, found, hi); else n_pass++;
            if (prev >= 0) begin
                n_checks++; if (cyc - prev != PER) $display("FAIL rand%0d_period got %0d want %0d", i, cyc - prev, PER); else n_pass++;
            end
            prev = cyc;
            run_on(1'b1, len, pk, mx);
            model_on(ipk, elen, epk);
            n_checks++; if (len != elen || pk !== epk || mx !== !epk) $display("FAIL rand%0d_on got len=%0d pk=%b mx=%b want len=%0d pk=%b mx=%b", i, len, pk, mx, elen, epk, !epk); else n_pass++;
        end
        tick();
    endtask

    task automatic test_enable();
        bit found, pk, mx, epk;
        int hi, len, elen;
        bus.ipk_code = 12'd1637;
        fill_const(IEST_ZERO_CODE);
        wait_start(found, hi);
        n_checks++; if (!found) $display("FAIL enable_first_start got 0 want 1"); else n_pass++;
        repeat (5) tick();
        bus.enable = 1'b0;
        tick();
        n_checks++; if (bus.pwm !== 1'b0) $display("FAIL enable_drop_pwm got %b want 0", bus.pwm); else n_pass++;
        n_checks++; if (bus.trip_pk !== 1'b0 || bus.trip_max !== 1'b0) $display("FAIL enable_drop_trip got pk=%b mx=%b want 0 0", bus.trip_pk, bus.trip_max); else n_pass++;
        while ((cyc % PER) != 20) tick();
        bus.enable = 1'b1;
        wait_start(found, hi);
        n_checks++; if (!found || (cyc % PER) != 0 || hi != 0) $display("FAIL enable_mid_period got found=%0d phase=%0d runt=%0d want 1 0 0", found, cyc % PER, hi); else n_pass++;
        run_on(1'b0, len, pk, mx);
        model_on(12'd1637, elen, epk);
        n_checks++; if (len != elen || pk !== epk) $display("FAIL enable_resume_on got len=%0d pk=%b want len=%0d pk=%b", len, pk, elen, epk); else n_pass++;
        tick();
    endtask

    task automatic test_fault();
        bit found, pk, mx, epk;
        int hi, len, elen, starts;
        bus.ipk_code = 12'd1637;
        fill_const(IEST_ZERO_CODE);
        wait_start(found, hi);
        repeat (3) tick();
        bus.fault = 1'b1;
        tick();
        bus.fault = 1'b0;
        n_checks++; if (bus.pwm !== 1'b0) $display("FAIL fault_pwm got %b want 0", bus.pwm); else n_pass++;
        n_checks++; if (bus.fault_lat !== 1'b1) $display("FAIL fault_lat_set got %b want 1", bus.fault_lat); else n_pass++;
        n_checks++; if (bus.trip_pk !== 1'b0 || bus.trip_max !== 1'b0) $display("FAIL fault_trip got pk=%b mx=%b want 0 0", bus.trip_pk, bus.trip_max); else n_pass++;
        hi = 0;
        starts = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            tick();
            if (bus.pwm !== 1'b0) hi++;
            if (bus.period_start !== 1'b0) starts++;
        end
        n_checks++; if (hi != 0 || starts != 0 || bus.fault_lat !== 1'b1) $display("FAIL fault_hold got pwm_high=%0d starts=%0d lat=%b want 0 0 1", hi, starts, bus.fault_lat); else n_pass++;
        bus.enable = 1'b0;
        tick();
        n_checks++; if (bus.fault_lat !== 1'b0) $display("FAIL fault_lat_clear got %b want 0", bus.fault_lat); else n_pass++;
        bus.enable = 1'b1;
        wait_start(found, hi);
        n_checks++; if (!found || (cyc % PER) != 0 || hi != 0) $display("FAIL fault_restart got found=%0d phase=%0d runt=%0d want 1 0 0", found, cyc % PER, hi); else n_pass++;
        run_on(1'b0, len, pk, mx);
        model_on(12'd1637, elen, epk);
        n_checks++; if (len != elen || mx !== !epk) $display("FAIL fault_restart_on got len=%0d mx=%b want len=%0d mx=%b", len, mx, elen, !epk); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_on();
        bit found, pk, mx;
        int hi, len;
        bus.ipk_code = 12'd1637;
        fill_const(IEST_ZERO_CODE);
        wait_start(found, hi);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        n_checks++; if (bus.pwm !== 1'b0 || bus.period_start !== 1'b0 || bus.fault_lat !== 1'b0) $display("FAIL reset_mid_on got pwm=%b ps=%b lat=%b want 0 0 0", bus.pwm, bus.period_start, bus.fault_lat); else n_pass++;
        reset = 1'b0;
        cyc = 0;
        wait_start(found, hi);
        n_checks++; if (!found || cyc != PER) $display("FAIL reset_restart got found=%0d cyc=%0d want cyc=%0d", found, cyc, PER); else n_pass++;
        run_on(1'b0, len, pk, mx);
        tick();
    endtask

    initial begin
`ifdef PWM_SLOPE_COMP_EN
        bus.slope = 8'd0;
`endif
        test_reset();
        test_startup();
        test_peak();
        test_blanking();
        test_coincide();
        test_ipk_fff();
        test_random(24);
        test_enable();
        test_fault();
        test_reset_mid_on();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
